// File: rtl/rr_onehot_arbiter_pkg.sv
// ============================================================================
// Module  : arb_pkg
// Brief   : Shared state encoding and default sizing for rr_onehot_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int c_num_req     = 16;
    localparam int c_idx_w       = 4;
    localparam int c_timeout_cyc = 255;

endpackage

`default_nettype wire

// File: rtl/rr_onehot_arbiter_binary_to_one_hot.sv
// ============================================================================
// Module  : binary_to_one_hot
// Brief   : Combinational binary index to one-hot decoder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module binary_to_one_hot
    import arb_pkg::*;
#(
    parameter int NUM_OUT = c_num_req,
    parameter int IDX_W   = c_idx_w
) (
    input  logic [IDX_W-1:0]   idx_i,
    output logic [NUM_OUT-1:0] one_hot_o
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_bit
            assign one_hot_o[gi] = (idx_i == IDX_W'(gi));
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/rr_onehot_arbiter.sv
// ============================================================================
// Module  : rr_onehot_arbiter
// Brief   : Round-robin arbiter with held grant, binary and one-hot outputs.
//           Optional hold timeout enabled by defining ARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_onehot_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ     = c_num_req,
    parameter int IDX_W       = c_idx_w,
    parameter int TIMEOUT_CYC = c_timeout_cyc
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               done_i,
    output logic               gnt_valid_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic [NUM_REQ-1:0] gnt_one_hot_o,
    output logic               timeout_o
);

    arb_state_e         r_state;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_ptr;

    logic               w_hold_expired;
    logic               w_release;
    logic [IDX_W-1:0]   w_start;
    logic [NUM_REQ-1:0] w_search_vec;
    logic [IDX_W-1:0]   w_win;
    logic               w_found;
    logic [NUM_REQ-1:0] w_dec;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        logic [IDX_W:0] s;
        s = {1'b0, v} + 1'b1;
        if (s >= (IDX_W+1)'(NUM_REQ)) s = '0;
        return s[IDX_W-1:0];
    endfunction

    // Walk offsets from the far end so the lowest offset from start wins.
    function automatic void rr_search(
        input  logic [IDX_W-1:0]   start,
        input  logic [NUM_REQ-1:0] vec,
        output logic [IDX_W-1:0]   win,
        output logic               found
    );
        logic [IDX_W:0] cand;
        win   = '0;
        found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, start} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
            if (vec[cand[IDX_W-1:0]]) begin
                win   = cand[IDX_W-1:0];
                found = 1'b1;
            end
        end
    endfunction

    always_comb begin
        w_release    = (r_state == ARB_GRANT) &&
                       (done_i || !req_i[r_owner] || w_hold_expired);
        w_start      = w_release ? wrap_inc(r_owner) : r_ptr;
        w_search_vec = w_release ? (req_i & ~(NUM_REQ'(1) << r_owner)) : req_i;
        rr_search(w_start, w_search_vec, w_win, w_found);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ARB_IDLE;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_win;
                        r_state <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    if (w_release) begin
                        r_ptr <= w_start;
                        if (w_found) r_owner <= w_win;
                        else         r_state <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(TIMEOUT_CYC + 1);

    logic [HOLD_W-1:0] r_hold;
    logic              r_forced;

    assign w_hold_expired = (r_state == ARB_GRANT) &&
                            (r_hold == HOLD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_hold    <= '0;
            r_forced  <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            if ((r_state == ARB_IDLE) || w_release) r_hold <= '0;
            else                                    r_hold <= r_hold + 1'b1;
            // Only a release caused purely by the counter counts as a timeout.
            r_forced  <= w_hold_expired && !done_i && req_i[r_owner];
            timeout_o <= r_forced;
        end
    end
`else
    logic w_unused_timeout_cfg;

    assign w_unused_timeout_cfg = (TIMEOUT_CYC > 0);
    assign w_hold_expired       = 1'b0;
    assign timeout_o            = 1'b0;
`endif

    binary_to_one_hot #(
        .NUM_OUT (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_dec (
        .idx_i     (r_owner),
        .one_hot_o (w_dec)
    );

    // Output stage re-registers arbitration state so index and one-hot move together.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            gnt_valid_o   <= 1'b0;
            gnt_idx_o     <= '0;
            gnt_one_hot_o <= '0;
        end else begin
            gnt_valid_o   <= (r_state == ARB_GRANT);
            gnt_idx_o     <= r_owner;
            gnt_one_hot_o <= w_dec & {NUM_REQ{r_state == ARB_GRANT}};
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rr_onehot_arbiter.sv
// ============================================================================
// Module  : tb_rr_onehot_arbiter
// Brief   : Scoreboard bench for rr_onehot_arbiter (timeout scenario only
//           when ARB_TIMEOUT_EN is defined).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_onehot_arbiter;

    localparam int N  = 16;
    localparam int W  = 4;
    localparam int TC = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic [N-1:0] req_i;
    logic         done_i;
    logic         gnt_valid_o;
    logic [W-1:0] gnt_idx_o;
    logic [N-1:0] gnt_one_hot_o;
    logic         timeout_o;

    rr_onehot_arbiter #(
        .NUM_REQ     (N),
        .IDX_W       (W),
        .TIMEOUT_CYC (TC)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .req_i         (req_i),
        .done_i        (done_i),
        .gnt_valid_o   (gnt_valid_o),
        .gnt_idx_o     (gnt_idx_o),
        .gnt_one_hot_o (gnt_one_hot_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic         valid;
        logic [W-1:0] idx;
        logic [N-1:0] oh;
        logic         to;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    bit m_grant;
    int m_owner, m_ptr, m_hold;

    function automatic logic [21:0] obs_vec();
        return {gnt_valid_o, gnt_valid_o ? gnt_idx_o : 4'h0, gnt_one_hot_o, timeout_o};
    endfunction

    function automatic logic [21:0] exp_vec(input exp_t e);
        return {e.valid, e.valid ? e.idx : 4'h0, e.oh, e.to};
    endfunction

    task automatic find(input int s, input logic [N-1:0] v, output int w, output bit f);
        int c;
        w = 0;
        f = 1'b0;
        for (int k = 0; k < N; k++) begin
            c = (s + k) % N;
            if (v[c]) begin
                w = c;
                f = 1'b1;
                return;
            end
        end
    endtask

    task automatic model_reset();
        m_grant = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_hold  = 0;
        sb.delete();
        sb.push_back('0);
    endtask

    // Reference arbitration step for one clock edge; pushes the outputs that
    // appear one edge later.
    task automatic model_edge();
        exp_t e;
        int   w;
        bit   f, expired, rel, forced;
        forced = 1'b0;
        if (!m_grant) begin
            find(m_ptr, req_i, w, f);
            if (f) begin
                m_grant = 1'b1;
                m_owner = w;
                m_hold  = 0;
            end
        end else begin
            expired = TO_EN && (m_hold == TC - 1);
            rel     = done_i || !req_i[m_owner] || expired;
            forced  = expired && !done_i && req_i[m_owner];
            if (rel) begin
                m_ptr = (m_owner + 1) % N;
                find(m_ptr, req_i & ~(16'h0001 << m_owner), w, f);
                if (f) begin
                    m_owner = w;
                    m_hold  = 0;
                end else begin
                    m_grant = 1'b0;
                end
            end else begin
                m_hold++;
            end
        end
        e.valid = m_grant;
        e.idx   = W'(m_owner);
        e.oh    = m_grant ? (16'h0001 << m_owner) : 16'h0000;
        e.to    = forced;
        sb.push_back(e);
    endtask

    task automatic tick(output exp_t e);
        model_edge();
        @(posedge clk_i);
        #1;
        e = sb.pop_front();
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n_i = 1'b0;
        req_i   = 16'hFFFF;
        done_i  = 1'b0;
        #3;
        checks++;
        if ({gnt_valid_o, gnt_idx_o, gnt_one_hot_o, timeout_o} !== 22'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b idx=%0d oh=%h to=%b, expected all zero",
                     gnt_valid_o, gnt_idx_o, gnt_one_hot_o, timeout_o);
        end
        model_reset();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(e);
            checks++;
            if (obs_vec() !== exp_vec(e)) begin
                errors++;
                $display("FAIL reset_release cyc %0d: got %h expected %h", i, obs_vec(), exp_vec(e));
            end
        end
        checks++;
        if (gnt_valid_o !== 1'b1 || gnt_idx_o !== 4'd0 || gnt_one_hot_o !== 16'h0001) begin
            errors++;
            $display("FAIL reset_first_grant: got v=%b idx=%0d oh=%h, expected v=1 idx=0 oh=0001",
                     gnt_valid_o, gnt_idx_o, gnt_one_hot_o);
        end
    endtask

    task automatic test_rotation();
        exp_t e;
        int   seq[5] = '{0, 4, 15, 0, 4};
        req_i = 16'h8011;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (gnt_valid_o !== 1'b1 || gnt_idx_o !== W'(seq[k])) begin
                errors++;
                $display("FAIL rotation_idx step %0d: got v=%b idx=%0d, expected v=1 idx=%0d",
                         k, gnt_valid_o, gnt_idx_o, seq[k]);
            end
            if (k < 4) begin
                for (int p = 0; p < 2; p++) begin
                    done_i = (p == 0);
                    tick(e);
                    checks++;
                    if (obs_vec() !== exp_vec(e)) begin
                        errors++;
                        $display("FAIL rotation step %0d.%0d: got %h expected %h", k, p, obs_vec(), exp_vec(e));
                    end
                end
            end
        end
        done_i = 1'b0;
    endtask

    task automatic test_withdrawal();
        exp_t           e;
        logic [N-1:0]   pat[4] = '{16'h0008, 16'h0000, 16'h0004, 16'h0000};
        logic [W:0]     want[4] = '{{1'b1, 4'd3}, {1'b0, 4'd0}, {1'b1, 4'd2}, {1'b0, 4'd0}};
        for (int s = 0; s < 4; s++) begin
            req_i = pat[s];
            for (int p = 0; p < 2; p++) begin
                tick(e);
                checks++;
                if (obs_vec() !== exp_vec(e)) begin
                    errors++;
                    $display("FAIL withdrawal phase %0d.%0d: got %h expected %h", s, p, obs_vec(), exp_vec(e));
                end
            end
            checks++;
            if (gnt_valid_o !== want[s][W] || (want[s][W] && gnt_idx_o !== want[s][W-1:0])) begin
                errors++;
                $display("FAIL withdrawal_grant phase %0d: got v=%b idx=%0d, expected v=%b idx=%0d",
                         s, gnt_valid_o, gnt_idx_o, want[s][W], want[s][W-1:0]);
            end
        end
    endtask

    task automatic test_sole_requester();
        exp_t e;
        logic v_seen[6];
        req_i = 16'h0020;
        for (int c = 0; c < 6; c++) begin
            done_i = (c == 2);
            tick(e);
            v_seen[c] = gnt_valid_o;
            checks++;
            if (obs_vec() !== exp_vec(e)) begin
                errors++;
                $display("FAIL sole_requester cyc %0d: got %h expected %h", c, obs_vec(), exp_vec(e));
            end
        end
        checks++;
        if (v_seen[2] !== 1'b1 || v_seen[3] !== 1'b0 || v_seen[4] !== 1'b1 || gnt_idx_o !== 4'd5) begin
            errors++;
            $display("FAIL sole_bubble: got valid %b%b%b idx=%0d, expected valid 101 idx=5",
                     v_seen[2], v_seen[3], v_seen[4], gnt_idx_o);
        end
        done_i = 1'b0;
        req_i  = 16'h0000;
        for (int c = 0; c < 2; c++) begin
            tick(e);
            checks++;
            if (obs_vec() !== exp_vec(e)) begin
                errors++;
                $display("FAIL sole_drain cyc %0d: got %h expected %h", c, obs_vec(), exp_vec(e));
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        req_i = 16'h0080;
        for (int c = 0; c < 2; c++) begin
            tick(e);
            checks++;
            if (obs_vec() !== exp_vec(e)) begin
                errors++;
                $display("FAIL async_setup cyc %0d: got %h expected %h", c, obs_vec(), exp_vec(e));
            end
        end
        checks++;
        if (gnt_valid_o !== 1'b1 || gnt_idx_o !== 4'd7) begin
            errors++;
            $display("FAIL async_pre_grant: got v=%b idx=%0d, expected v=1 idx=7", gnt_valid_o, gnt_idx_o);
        end
        @(negedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        checks++;
        if (gnt_valid_o !== 1'b0 || gnt_one_hot_o !== 16'h0000 || gnt_idx_o !== 4'd0) begin
            errors++;
            $display("FAIL async_drop: got v=%b idx=%0d oh=%h, expected all zero before clock edge",
                     gnt_valid_o, gnt_idx_o, gnt_one_hot_o);
        end
        model_reset();
        req_i = 16'h0081;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick(e);
            checks++;
            if (obs_vec() !== exp_vec(e)) begin
                errors++;
                $display("FAIL async_after cyc %0d: got %h expected %h", c, obs_vec(), exp_vec(e));
            end
        end
        checks++;
        if (gnt_valid_o !== 1'b1 || gnt_idx_o !== 4'd0) begin
            errors++;
            $display("FAIL async_ptr_zero: got v=%b idx=%0d, expected v=1 idx=0", gnt_valid_o, gnt_idx_o);
        end
        req_i = 16'h0000;
        for (int c = 0; c < 2; c++) begin
            tick(e);
            checks++;
            if (obs_vec() !== exp_vec(e)) begin
                errors++;
                $display("FAIL async_drain cyc %0d: got %h expected %h", c, obs_vec(), exp_vec(e));
            end
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        int   cnt1   = 0;
        int   to_cnt = 0;
        int   to_idx = -1;
        req_i  = 16'h0006;
        done_i = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick(e);
            checks++;
            if (obs_vec() !== exp_vec(e)) begin
                errors++;
                $display("FAIL timeout cyc %0d: got %h expected %h", c, obs_vec(), exp_vec(e));
            end
            if (gnt_valid_o && gnt_idx_o == 4'd1) cnt1++;
            if (timeout_o) begin
                to_cnt++;
                to_idx = int'(gnt_idx_o);
            end
        end
        checks++;
        if (cnt1 != 8 || to_cnt != 1 || to_idx != 2) begin
            errors++;
            $display("FAIL timeout_summary: got hold=%0d pulses=%0d idx_at_pulse=%0d, expected 8 1 2",
                     cnt1, to_cnt, to_idx);
        end
        req_i = 16'h0000;
    endtask
`endif

    initial begin
        test_reset();
        test_rotation();
        test_withdrawal();
        test_sole_requester();
        test_async_reset();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rr_onehot_arbiter.md
# rr_onehot_arbiter

Round-robin arbiter sharing one downstream resource among up to 16 requesters. It issues a registered grant as a binary index and as a one-hot vector, and holds the grant until the owner releases it. Grant priority rotates so that no requester starves. It sits between the requesting channels and the shared datapath, and drives that datapath's select lines.

## Interface
- NUM_REQ, 16, number of requesters (2..16)
- IDX_W, 4, grant index width, equal to clog2(NUM_REQ)
- TIMEOUT_CYC, 255, maximum hold cycles per grant (used only with ARB_TIMEOUT_EN)
- clk_i  input  1  clock, rising edge
- rst_n_i  input  1  reset, asynchronous and active-low
- req_i  input  NUM_REQ  request vector, level-sensitive
- done_i  input  1  owner releases the grant this cycle
- gnt_valid_o  output  1  a grant is active
- gnt_idx_o  output  IDX_W  binary index of the current owner
- gnt_one_hot_o  output  NUM_REQ  one-hot owner; all-zero when gnt_valid_o=0
- timeout_o  output  1  one-cycle pulse on a forced release (ARB_TIMEOUT_EN only)

## Operation
- States:
  - IDLE: no owner.
  - GRANT: one owner held.
- Rotating pointer ptr[IDX_W-1:0]. The search starts at ptr and wraps modulo NUM_REQ. The first set req_i bit wins.
- IDLE with req_i!=0: register winner w, then go to GRANT.
- IDLE with req_i==0: stay in IDLE.
- GRANT: hold w, ignoring all other requests.
- Release event, either of:
  - done_i=1
  - req_i[w]=0 (requester withdrew)
- On release:
  - ptr <= (w+1) mod NUM_REQ.
  - The same-cycle search starts at (w+1) mod NUM_REQ, with req_i[w] masked out.
  - A winner exists: stay in GRANT with the new owner (back-to-back, no bubble).
  - No winner: go to IDLE.
- The sole requester re-requesting after release is granted again, with one IDLE cycle between grants because it is masked in the release cycle.
- done_i while in IDLE is ignored.
- Requests with index >= NUM_REQ do not exist. Arithmetic wraps at NUM_REQ, not at 2^IDX_W.
- Reset values:
  - state IDLE, ptr 0
  - gnt_valid_o 0, gnt_idx_o 0, gnt_one_hot_o 0, timeout_o 0
- Reset asserted mid-grant drops the grant immediately (asynchronously). ptr returns to 0.

## Timing
- All outputs are registered. There is no combinational path from req_i or done_i to any output.
- Request sampled at edge N in IDLE: gnt_valid_o=1 after edge N+1 (1-cycle latency).
- done_i sampled at edge M:
  - Grant changes or drops after edge M+1.
  - gnt_one_hot_o is consistent with gnt_idx_o in every cycle.
- Back-to-back handover: gnt_valid_o stays 1 and gnt_idx_o changes in a single cycle.
- First edge after rst_n_i deasserts: arbitration starts from ptr=0.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A hold counter clears on every new grant and increments each cycle in GRANT.
  - When the counter reaches TIMEOUT_CYC-1 without a release, a forced release occurs with the same semantics as done_i.
  - timeout_o pulses high for 1 cycle, aligned with the grant change.
- ARB_TIMEOUT_EN undefined:
  - No counter.
  - timeout_o tied to 0.
  - A grant is held indefinitely until release.

## Structure
- Shared package (arb_pkg) holds:
  - the state enum (ARB_IDLE, ARB_GRANT)
  - default constants for NUM_REQ, IDX_W, TIMEOUT_CYC
- Sub-module: binary_to_one_hot decodes gnt_idx_o to one-hot. Its output is ANDed with gnt_valid_o and registered.
- The rotating priority search is a combinational function: ptr and mask in, winner index and found flag out.

## Test plan
- Reset behaviour: rst_n_i=0 with req_i=16'hFFFF → all outputs 0. Release reset → gnt_idx_o=0 and gnt_one_hot_o=16'h0001 one cycle later.
- Rotation: req_i=16'h8011 held, done_i pulsed once per grant → idx sequence 0, 4, 15, 0, 4, with no bubbles.
- Withdrawal: requester 3 granted, then req_i[3] dropped with no other requests → gnt_valid_o=0 next cycle. Assert req_i[2] → granted with idx 2; wrap search confirmed from ptr=4.
- Sole requester: req_i=16'h0020 held, done_i pulsed → grant drops for 1 cycle, then idx 5 again.
- Async reset mid-grant: rst_n_i falls while idx=7 is granted → gnt_valid_o=0 without waiting for a clock edge. After release, ptr=0.
- ARB_TIMEOUT_EN with TIMEOUT_CYC=8: req_i=16'h0006 and done_i held 0 → idx 1 for 8 cycles, then timeout_o pulses and idx becomes 2.
